uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, width of baud divider input.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port div  input  DIV_WIDTH  baud divider; bit period P = div+2 clk cycles.
REQ-006 SHALL have port data  output  8  last received byte, LSB received first.
REQ-007 SHALL have port valid  output  1  one-cycle strobe, data holds a good byte.
REQ-008 SHALL have port ferr  output  1  one-cycle strobe, framing error (stop bit sampled low).

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; the synchronized line is rxs; all decisions use rxs.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 IDLE: on rxs=0 SHALL load the divider counter with div>>1 and enter START.
REQ-012 Divider: counter of DIV_WIDTH+1 bits, counts down; sample tick when MSB set (underflow), then reload with div; tick period P.
REQ-013 START: first tick SHALL sample rxs; 0 -> enter DATA with bit count 0; 1 -> false start, return to IDLE, no strobe.
REQ-014 DATA: on each tick SHALL shift rxs into bit 7 of an 8-bit shift register (right shift); after the 8th tick enter STOP.
REQ-015 STOP: on tick, rxs=1 -> data <= shift register, valid=1 next cycle, enter IDLE.
REQ-016 STOP: on tick, rxs=0 -> data <= shift register, ferr=1 next cycle, valid stays 0, enter WAIT_HIGH.
REQ-017 WAIT_HIGH: SHALL stay until rxs=1, then enter IDLE; no start detected while here (break handling).
REQ-018 valid and ferr SHALL each be high exactly one cycle per frame and never simultaneously.
REQ-019 data SHALL hold its value between frames; it changes only in the cycle valid or ferr asserts.
REQ-020 Back-to-back frames: a start bit beginning immediately after a good stop sample SHALL be received without loss.
REQ-021 div SHALL be sampled at each reload; changing div mid-frame is undefined; div=0 gives P=2, minimum supported.
REQ-022 No flow control: a new valid overwrites data regardless of consumer.

Reset
REQ-023 rst SHALL force state IDLE, valid=0, ferr=0, data=8'h00, synchronizer and filter flops to 1, counter and bit count cleared.
REQ-024 rst mid-frame SHALL abort the frame with no strobe; reception resumes at the next falling edge after rst deasserts.

Configuration
REQ-025 Macro UART_RX_FILTER_EN defined: rxs SHALL be replaced by a 3-sample majority vote of the last three synchronized samples (one extra cycle latency, flops reset to 1); single-cycle glitches rejected.
REQ-026 Macro UART_RX_FILTER_EN undefined: no majority filter, rxs is the raw synchronizer output; all other behaviour identical.

Verification
REQ-027 div=8 (P=10), send 0x55 with good stop -> exactly one valid pulse, data=8'h55, ferr never high.
REQ-028 div=8, rx low for 3 cycles then high -> no valid, no ferr, FSM back in IDLE; following 0xA3 frame received correctly.
REQ-029 div=8, send 0xA3 with stop bit low, hold rx low 50 cycles -> one ferr pulse, data=8'hA3, no valid; no new frame until rx high, then 0x3C received with valid.
REQ-030 div=8, send 0x00, 0xFF, 0x81 back-to-back -> three valid pulses, data 8'h00, 8'hFF, 8'h81 in order.
REQ-031 Assert rst for 1 cycle during data bit 4 of 0x5A -> no strobe, data=8'h00; next frame 0x12 received correctly.
REQ-032 With UART_RX_FILTER_EN, div=8, 1-cycle inverted glitch on rx at the bit-2 sample point of 0x0F -> data=8'h0F; without macro same stimulus -> data=8'h0B.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial-receiver port bundle: line and divider in, byte and strobes out.
interface uart_rx_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 rx;
  logic [DIV_WIDTH-1:0] div;
  logic [7:0]           data;
  logic                 valid;
  logic                 ferr;

  modport master (output rx, div, input data, valid, ferr);
  modport slave  (input rx, div, output data, valid, ferr);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, bit period div+2 clocks, one-cycle valid/ferr strobes.
// Optional 3-sample majority glitch filter: define UART_RX_FILTER_EN.
module uart_rx #(
  parameter int DIV_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t               r_state;
  logic                 r_s1, r_s2;
  logic [DIV_WIDTH:0]   r_cnt;
  logic [2:0]           r_bitcnt;
  logic [7:0]           r_shift;
  logic [7:0]           r_data;
  logic                 r_valid, r_ferr;
  logic                 w_rxs;
  logic                 w_tick;
  logic [DIV_WIDTH-1:0] w_half;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= bus.rx;
      r_s2 <= r_s1;
    end
  end

`ifdef UART_RX_FILTER_EN
  logic [1:0] r_flt;
  always_ff @(posedge clk) begin
    if (rst) r_flt <= 2'b11;
    else     r_flt <= {r_flt[0], r_s2};
  end
  assign w_rxs = (r_s2 & r_flt[0]) | (r_s2 & r_flt[1]) | (r_flt[0] & r_flt[1]);
`else
  assign w_rxs = r_s2;
`endif

  // Counter runs div..0 then wraps to all-ones; the MSB marks the sample tick.
  assign w_tick = r_cnt[DIV_WIDTH];
  assign w_half = bus.div >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_state == START || r_state == DATA || r_state == STOP) begin
        if (w_tick) r_cnt <= {1'b0, bus.div};
        else        r_cnt <= r_cnt - {{DIV_WIDTH{1'b0}}, 1'b1};
      end
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= {1'b0, w_half};
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_bitcnt <= '0;
            r_state  <= w_rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift  <= {w_rxs, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_data <= r_shift;
            if (w_rxs) begin
              r_valid <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end
        end
        // Break condition: ignore the line until it returns high.
        WAIT_HIGH: begin
          if (w_rxs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data  = r_data;
  assign bus.valid = r_valid;
  assign bus.ferr  = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random frames vs. a frame-level expected-event queue.
module tb_uart_rx;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   p_bit  = 10;
  int   viol   = 0;
  int   exp_q[$];
  int   obs_q[$];
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx_if #(.DIV_WIDTH(DW)) bus ();
  uart_rx #(.DIV_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Collect strobes; flag overlap and any data change not accompanied by a strobe.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.valid && bus.ferr) viol++;
      if (bus.data != prev_data && !bus.valid && !bus.ferr) viol++;
      if (bus.valid || bus.ferr) obs_q.push_back((bus.ferr ? 256 : 0) + int'(bus.data));
    end
    prev_data = bus.data;
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx = v;
    end
  endtask

  task automatic set_div(input int d);
    @(negedge clk);
    bus.div = DW'(d);
    p_bit   = d + 2;
  endtask

  // One 8N1 frame, one drive per clock; optional one-cycle glitch and mid-frame reset.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low,
                            input int glitch_at, input int abort_at);
    logic v;
    int   k;
    for (int i = 0; i < 10 * p_bit; i++) begin
      if (i == abort_at) begin
        @(negedge clk);
        rst    = 1'b1;
        bus.rx = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        return;
      end
      k = i / p_bit;
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop_ok;
      else             v = b[k-1];
      if (i == glitch_at) v = ~v;
      drive(v, 1);
    end
    if (!stop_ok) drive(1'b0, hold_low);
  endtask

  task automatic expect_ev(input bit is_ferr, input logic [7:0] b);
    exp_q.push_back((is_ferr ? 256 : 0) + int'(b));
  endtask

  task automatic flush(input string tag);
    int n;
    drive(1'b1, 3 * p_bit + 10);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] glitch_exp;
    bit         ok;
    int         half;

    rst     = 1'b1;
    bus.rx  = 1'b1;
    bus.div = DW'(8);
    repeat (3) @(negedge clk);
    chk("rst_data", int'(bus.data), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_ferr", int'(bus.ferr), 0);
    rst = 1'b0;
    set_div(8);
    drive(1'b1, 5);

    send_frame(8'h55, 1'b1, 0, -1, -1);
    expect_ev(1'b0, 8'h55);
    flush("good55");

    drive(1'b0, 3);
    drive(1'b1, 20);
    send_frame(8'hA3, 1'b1, 0, -1, -1);
    expect_ev(1'b0, 8'hA3);
    flush("falsestart");

    send_frame(8'hA3, 1'b0, 50, -1, -1);
    expect_ev(1'b1, 8'hA3);
    chk("break_data", int'(bus.data), 8'hA3);
    drive(1'b1, 5);
    send_frame(8'h3C, 1'b1, 0, -1, -1);
    expect_ev(1'b0, 8'h3C);
    flush("break");

    send_frame(8'h00, 1'b1, 0, -1, -1);
    send_frame(8'hFF, 1'b1, 0, -1, -1);
    send_frame(8'h81, 1'b1, 0, -1, -1);
    expect_ev(1'b0, 8'h00);
    expect_ev(1'b0, 8'hFF);
    expect_ev(1'b0, 8'h81);
    flush("b2b");

    send_frame(8'h5A, 1'b1, 0, -1, 5 * p_bit + p_bit / 2);
    drive(1'b1, 40);
    chk("abort_data", int'(bus.data), 0);
    flush("abort");
    send_frame(8'h12, 1'b1, 0, -1, -1);
    expect_ev(1'b0, 8'h12);
    flush("after_rst");

    // Glitch lands on the bit-2 sample point (half period + 2 into the bit window).
    half = 8 >> 1;
    send_frame(8'h0F, 1'b1, 0, 3 * p_bit + half + 2, -1);
`ifdef UART_RX_FILTER_EN
    glitch_exp = 8'h0F;
`else
    glitch_exp = 8'h0B;
`endif
    expect_ev(1'b0, glitch_exp);
    flush("glitch");

    for (int bt = 0; bt < 4; bt++) begin
      set_div($urandom_range(1, 20));
      drive(1'b1, 4);
      for (int f = 0; f < 6; f++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 3) != 0);
        if (ok) begin
          send_frame(b, 1'b1, 0, -1, -1);
          expect_ev(1'b0, b);
          drive(1'b1, $urandom_range(0, 5));
        end else begin
          send_frame(b, 1'b0, $urandom_range(0, 20), -1, -1);
          expect_ev(1'b1, b);
          drive(1'b1, $urandom_range(3, 8));
        end
      end
      flush("rand");
    end

    chk("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
